// File: rtl/level_pkg.sv
// level_pkg: level geometry, probe FSM states, probe indices and side masks (PROBE_CENTER_EN adds mid-edge probes)
package level_pkg;
  localparam int LEFT = 143;
  localparam int TOP = 34;
  localparam int ROW_MAX = 14;
  localparam int COL_MAX = 19;
  localparam int TILE_SHIFT = 5;
  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;
  localparam int P_L0 = 0;
  localparam int P_L1 = 1;
  localparam int P_R0 = 2;
  localparam int P_R1 = 3;
  localparam int P_U0 = 4;
  localparam int P_U1 = 5;
  localparam int P_D0 = 6;
  localparam int P_D1 = 7;
`ifdef PROBE_CENTER_EN
  localparam int P_LC = 8;
  localparam int P_RC = 9;
  localparam int P_UC = 10;
  localparam int P_DC = 11;
  localparam int NUM_PROBES = 12;
  localparam int IDX_W = 4;
  localparam logic [NUM_PROBES-1:0] M_LEFT = 12'b0001_0000_0011;
  localparam logic [NUM_PROBES-1:0] M_RIGHT = 12'b0010_0000_1100;
  localparam logic [NUM_PROBES-1:0] M_UP = 12'b0100_0011_0000;
  localparam logic [NUM_PROBES-1:0] M_DOWN = 12'b1000_1100_0000;
`else
  localparam int NUM_PROBES = 8;
  localparam int IDX_W = 3;
  localparam logic [NUM_PROBES-1:0] M_LEFT = 8'b0000_0011;
  localparam logic [NUM_PROBES-1:0] M_RIGHT = 8'b0000_1100;
  localparam logic [NUM_PROBES-1:0] M_UP = 8'b0011_0000;
  localparam logic [NUM_PROBES-1:0] M_DOWN = 8'b1100_0000;
`endif
endpackage

// File: rtl/probe_point_gen.sv
// probe_point_gen: maps snapshot position and probe index to a probe coordinate and an off-map flag
module probe_point_gen
  import level_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int STEP = 1
) (
  input  logic [9:0]       sx,
  input  logic [9:0]       sy,
  input  logic [IDX_W-1:0] idx,
  output logic [9:0]       x,
  output logic [9:0]       y,
  output logic             oob
);
  localparam logic signed [11:0] Z = 12'sd0;
  localparam logic signed [11:0] OL = 12'(-STEP);
  localparam logic signed [11:0] OR = 12'(SPR_W - 1 + STEP);
  localparam logic signed [11:0] ER = 12'(SPR_W - 1);
  localparam logic signed [11:0] OT = 12'(-STEP);
  localparam logic signed [11:0] OB = 12'(SPR_H - 1 + STEP);
  localparam logic signed [11:0] EB = 12'(SPR_H - 1);
  localparam logic signed [11:0] MX = 12'(SPR_W / 2 - 1);
  localparam logic signed [11:0] MY = 12'(SPR_H / 2 - 1);
  logic signed [11:0] dx, dy, xs, ys;
  always_comb begin
    {dx, dy} = {Z, Z};
    case (idx)
      IDX_W'(P_L0): {dx, dy} = {OL, Z};
      IDX_W'(P_L1): {dx, dy} = {OL, EB};
      IDX_W'(P_R0): {dx, dy} = {OR, Z};
      IDX_W'(P_R1): {dx, dy} = {OR, EB};
      IDX_W'(P_U0): {dx, dy} = {Z, OT};
      IDX_W'(P_U1): {dx, dy} = {ER, OT};
      IDX_W'(P_D0): {dx, dy} = {Z, OB};
      IDX_W'(P_D1): {dx, dy} = {ER, OB};
`ifdef PROBE_CENTER_EN
      IDX_W'(P_LC): {dx, dy} = {OL, MY};
      IDX_W'(P_RC): {dx, dy} = {OR, MY};
      IDX_W'(P_UC): {dx, dy} = {MX, OT};
      IDX_W'(P_DC): {dx, dy} = {MX, OB};
`endif
      default: {dx, dy} = {Z, Z};
    endcase
  end
  assign xs = $signed({2'b00, sx}) + dx;
  assign ys = $signed({2'b00, sy}) + dy;
  assign x = xs[9:0];
  assign y = ys[9:0];
  // negative or above 1023 both show up in the top two bits
  assign oob = |{xs[11:10], ys[11:10]};
endmodule

// File: rtl/collision_probe.sv
// collision_probe: per-frame sprite edge probing into registered blocked flags (PROBE_CENTER_EN adds mid-edge probes)
module collision_probe
  import level_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] px,
  input  logic [9:0] py,
  output logic [9:0] probe_x,
  output logic [9:0] probe_y,
  input  logic       probe_hit,
  output logic       busy,
  output logic       done,
  output logic       blocked_left,
  output logic       blocked_right,
  output logic       blocked_up,
  output logic       blocked_down
);
  state_t state, next;
  logic [IDX_W-1:0] idx;
  logic [9:0] sx, sy, gx, gy;
  logic [NUM_PROBES-1:0] acc, acc_next;
  logic oob, last;
  probe_point_gen #(.SPR_W(SPR_W), .SPR_H(SPR_H), .STEP(STEP)) u_gen (
    .sx(sx), .sy(sy), .idx(idx), .x(gx), .y(gy), .oob(oob)
  );
  assign last = idx == IDX_W'(NUM_PROBES - 1);
  assign acc_next = acc | (NUM_PROBES'(oob | probe_hit) << idx);
  assign busy = state != IDLE;
  assign probe_x = state == PROBE ? gx : '0;
  assign probe_y = state == PROBE ? gy : '0;
  always_comb begin
    next = state;
    next = state == IDLE ? (start ? PROBE : IDLE) : state == PROBE ? (last ? DONE : PROBE) : IDLE;
  end
  // flags and done are registered together on the last probe so they are visible in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      sx <= '0;
      sy <= '0;
      acc <= '0;
      done <= 1'b0;
      {blocked_left, blocked_right, blocked_up, blocked_down} <= 4'b0;
    end else begin
      state <= next;
      done <= state == PROBE && last;
      if (state == IDLE && start) begin
        sx <= px;
        sy <= py;
        acc <= '0;
        idx <= '0;
      end
      if (state == PROBE) begin
        acc <= acc_next;
        idx <= last ? '0 : idx + 1'b1;
        if (last)
          {blocked_left, blocked_right, blocked_up, blocked_down} <=
            {|(acc_next & M_LEFT), |(acc_next & M_RIGHT), |(acc_next & M_UP), |(acc_next & M_DOWN)};
      end
    end
  end
endmodule

// File: tb/tb_collision_probe.sv
// tb_collision_probe: table-driven check of probe sequence, latency, flags and interference cases
module tb_collision_probe;
`ifdef PROBE_CENTER_EN
  localparam int NP = 12;
`else
  localparam int NP = 8;
`endif
  logic clk = 0, rst = 1, start = 0, probe_hit;
  logic [9:0] px = 0, py = 0, probe_x, probe_y;
  logic busy, done, blocked_left, blocked_right, blocked_up, blocked_down;
  int hit_mode = 0, n_tests = 0, n_fail = 0;
  int cap_x[NP], cap_y[NP];
  int done_cyc, done_cnt, busy_cnt, mid_fl;
  int exp_x[12] = '{199, 199, 232, 232, 200, 231, 200, 231, 199, 232, 215, 215};
  int exp_y[12] = '{100, 131, 100, 131, 99, 99, 132, 132, 115, 115, 99, 132};
  typedef struct { logic [9:0] x, y; int mode; logic [3:0] fl; } vec_t;
  vec_t v[$];

  collision_probe dut (
    .clk(clk), .rst(rst), .start(start), .px(px), .py(py),
    .probe_x(probe_x), .probe_y(probe_y), .probe_hit(probe_hit),
    .busy(busy), .done(done), .blocked_left(blocked_left), .blocked_right(blocked_right),
    .blocked_up(blocked_up), .blocked_down(blocked_down)
  );
  always #5 clk = ~clk;
  always_comb probe_hit = (hit_mode == 1 && probe_x == 10'd232) ||
                          (hit_mode == 2 && probe_x == 10'd199 && probe_y == 10'd115);

  function automatic int flags();
    return {28'b0, blocked_left, blocked_right, blocked_up, blocked_down};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // start at edge 0, then observe mid-cycle for 20 cycles; chg/rs/rc inject px change, restart, reset
  task automatic run(input logic [9:0] x, input logic [9:0] y, input int chg, input int rs, input int rc);
    @(negedge clk);
    px = x; py = y; start = 1;
    @(negedge clk);
    start = 0;
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; mid_fl = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
      if (c <= NP) begin cap_x[c-1] = int'(probe_x); cap_y[c-1] = int'(probe_y); end
      if (c == 5) mid_fl = flags();
      if (c == chg) px = 10'd0;
      start = c == rs;
      rst = c == rc;
    end
    start = 0; rst = 0;
  endtask

  initial begin
    int prev;
    v.push_back('{10'd200, 10'd100, 0, 4'b0000});
    v.push_back('{10'd200, 10'd100, 1, 4'b0100});
    v.push_back('{10'd0,   10'd0,   0, 4'b1010});
    v.push_back('{10'd1,   10'd1,   0, 4'b0000});
    v.push_back('{10'd991, 10'd991, 0, 4'b0000});
    v.push_back('{10'd992, 10'd100, 0, 4'b0100});
    v.push_back('{10'd100, 10'd992, 0, 4'b0001});
`ifdef PROBE_CENTER_EN
    v.push_back('{10'd200, 10'd100, 2, 4'b1000});
`endif
    rst = 1; start = 1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_flags", flags(), 0);
    chk("reset_probe_x", int'(probe_x), 0);
    chk("reset_probe_y", int'(probe_y), 0);
    rst = 0; start = 0;
    @(negedge clk);
    chk("post_reset_idle", int'(busy), 0);

    for (int i = 0; i < v.size(); i++) begin
      hit_mode = v[i].mode;
      prev = flags();
      run(v[i].x, v[i].y, 0, 0, 0);
      chk($sformatf("v%0d_done_cycle", i), done_cyc, NP + 1);
      chk($sformatf("v%0d_done_count", i), done_cnt, 1);
      chk($sformatf("v%0d_busy_cycles", i), busy_cnt, NP + 1);
      chk($sformatf("v%0d_flags", i), flags(), int'(v[i].fl));
      chk($sformatf("v%0d_flags_hold", i), mid_fl, prev);
      chk($sformatf("v%0d_idle_probe_x", i), int'(probe_x), 0);
      if (i == 0)
        for (int k = 0; k < NP; k++) begin
          chk($sformatf("seq_x%0d", k), cap_x[k], exp_x[k]);
          chk($sformatf("seq_y%0d", k), cap_y[k], exp_y[k]);
        end
    end

    hit_mode = 0;
    run(10'd200, 10'd100, 3, 4, 0);
    for (int k = 0; k < NP; k++) begin
      chk($sformatf("intf_x%0d", k), cap_x[k], exp_x[k]);
      chk($sformatf("intf_y%0d", k), cap_y[k], exp_y[k]);
    end
    chk("intf_done_cycle", done_cyc, NP + 1);
    chk("intf_done_count", done_cnt, 1);
    chk("intf_busy_cycles", busy_cnt, NP + 1);

    hit_mode = 1;
    run(10'd200, 10'd100, 0, 0, 0);
    chk("pre_rst_right", flags(), 4'b0100);
    hit_mode = 0;
    run(10'd200, 10'd100, 0, 0, 5);
    chk("rst_mid_done_count", done_cnt, 0);
    chk("rst_mid_busy_cycles", busy_cnt, 5);
    chk("rst_mid_flags", flags(), 0);
    chk("rst_mid_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
